// File: rtl/psum_pkg.sv
// Shared types and sizing helpers for the partial-sum collector.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_INT_BITS = 13;
    localparam int DEF_COLS     = 4;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_ACC_BITS = 16;

    // A one-row buffer still needs a 1-bit row index.
    function automatic int row_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int ROW_AW = row_aw(DEF_DEPTH);

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length shift register used to undo the systolic column skew.
module skew_delay_line
    import psum_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DELAY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DELAY; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/psum_collector.sv
// Deskews PE-array column psums, accumulates DEPTH-row tiles across K-passes
// and drains each finished tile row-by-row over valid/ready.
module psum_collector
    import psum_pkg::*;
#(
    parameter int INT_BITS = DEF_INT_BITS,
    parameter int COLS     = DEF_COLS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ACC_BITS = DEF_ACC_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [COLS*INT_BITS-1:0]  in_psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*ACC_BITS-1:0]  out_data,
    output logic [row_aw(DEPTH)-1:0]  out_row,
    output logic                      busy,
    output logic                      err
);

    localparam int RAW = row_aw(DEPTH);
    localparam logic [RAW-1:0] LAST_ROW = RAW'(DEPTH - 1);

    logic [COLS*INT_BITS-1:0] al_psum;
    logic                     al_valid, al_first, al_last;
    state_t                   state, state_nx;
    logic [RAW-1:0]           wr_row, rd_row;
    logic                     pass_first, pass_last;
    logic                     eff_first, eff_last, wr_en, rd_fire;
    logic [COLS*ACC_BITS-1:0] acc_buf [DEPTH];
    logic [COLS*ACC_BITS-1:0] new_row;

    // Lane j lags column 0 by j cycles, so it needs COLS-1-j more to line up.
    genvar j;
    generate
        for (j = 0; j < COLS; j++) begin : g_lane
            skew_delay_line #(.WIDTH(INT_BITS), .DELAY(COLS - 1 - j)) u_lane (
                .clk   (clk),
                .reset (reset),
                .din   (in_psum[j*INT_BITS +: INT_BITS]),
                .dout  (al_psum[j*INT_BITS +: INT_BITS])
            );
        end
    endgenerate

    skew_delay_line #(.WIDTH(3), .DELAY(COLS - 1)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .din   ({in_valid, in_first, in_last}),
        .dout  ({al_valid, al_first, al_last})
    );

    // Pass flags are live on row 0 and held in registers for the rest of the pass.
    assign eff_first = (wr_row == '0) ? al_first : pass_first;
    assign eff_last  = (wr_row == '0) ? al_last  : pass_last;
    assign wr_en     = al_valid && (state != DRAIN);
    assign rd_fire   = out_valid && out_ready;
    assign busy      = (state == DRAIN);
    assign out_row   = rd_row;

    always_comb begin
        new_row = '0;
        for (int k = 0; k < COLS; k++) begin
            new_row[k*ACC_BITS +: ACC_BITS] =
                (eff_first ? '0 : acc_buf[wr_row][k*ACC_BITS +: ACC_BITS])
                + ACC_BITS'(al_psum[k*INT_BITS +: INT_BITS]);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ACCUM: begin
                if (wr_en) begin
                    if (wr_row == LAST_ROW && eff_last) state_nx = DRAIN;
                    else                                state_nx = ACCUM;
                end
            end
            DRAIN: begin
                if (rd_fire && rd_row == LAST_ROW) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_row     <= '0;
            rd_row     <= '0;
            pass_first <= 1'b0;
            pass_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr_en) begin
                if (wr_row == '0) begin
                    pass_first <= al_first;
                    pass_last  <= al_last;
                end
                wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
                // Row 0 is only being written here when the tile is a single row.
                if (wr_row == LAST_ROW && eff_last) begin
                    out_valid <= 1'b1;
                    rd_row    <= '0;
                    out_data  <= (wr_row == '0) ? new_row : acc_buf[0];
                end
            end
            if (al_valid && state == DRAIN) err <= 1'b1;
            if (rd_fire) begin
                if (rd_row == LAST_ROW) begin
                    out_valid <= 1'b0;
                    rd_row    <= '0;
                end else begin
                    rd_row   <= rd_row + 1'b1;
                    out_data <= acc_buf[rd_row + 1'b1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) acc_buf[wr_row] <= new_row;
    end

endmodule

// File: tb/tb_psum_collector.sv
// Randomized bench for psum_collector with a row-level accumulation model.
module tb_psum_collector;
    import psum_pkg::*;

    localparam int INT_BITS = 13;
    localparam int COLS     = 4;
    localparam int DEPTH    = 8;
    localparam int ACC_BITS = 16;
    localparam int RAW      = 3;

    typedef logic [INT_BITS-1:0] lane_t;
    typedef struct {
        logic [RAW-1:0]           row;
        logic [COLS*ACC_BITS-1:0] data;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid, in_first, in_last;
    logic [COLS*INT_BITS-1:0] in_psum;
    logic                     out_valid, out_ready, busy, err;
    logic [COLS*ACC_BITS-1:0] out_data;
    logic [RAW-1:0]           out_row;

    always #5 clk = ~clk;

    psum_collector #(
        .INT_BITS(INT_BITS), .COLS(COLS), .DEPTH(DEPTH), .ACC_BITS(ACC_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .busy      (busy),
        .err       (err)
    );

    int    checks = 0;
    int    failures = 0;
    int    rdy_mode = 0;
    lane_t hist [COLS][COLS];
    lane_t vals [COLS];
    logic [ACC_BITS-1:0] mbuf [DEPTH][COLS];
    int    m_wr = 0;
    bit    m_first, m_last;
    exp_t  expq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One cycle: present column-0 row plus older rows on the skewed lanes, then compare at negedge.
    task automatic tick(input bit v, input bit f, input bit l);
        for (int k = COLS - 1; k > 0; k--) hist[k] = hist[k-1];
        for (int c = 0; c < COLS; c++) hist[0][c] = v ? vals[c] : '0;
        in_valid = v;
        in_first = v && f;
        in_last  = v && l;
        for (int c = 0; c < COLS; c++) in_psum[c*INT_BITS +: INT_BITS] = hist[c][c];
        case (rdy_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        @(negedge clk);
        if (!reset) begin
            check("busy_eq_valid", busy, out_valid);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_row actual_row=%0d data=%0h required=no_row", out_row, out_data);
                end else begin
                    check("drain_row", out_row, expq[0].row);
                    check("drain_data", out_data, expq[0].data);
                    if (out_ready) void'(expq.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input bit f, input bit l);
        exp_t e;
        if (m_wr == 0) begin
            m_first = f;
            m_last  = l;
        end
        for (int c = 0; c < COLS; c++)
            mbuf[m_wr][c] = (m_first ? '0 : mbuf[m_wr][c]) + ACC_BITS'(vals[c]);
        m_wr++;
        if (m_wr == DEPTH) begin
            m_wr = 0;
            if (m_last) begin
                for (int r = 0; r < DEPTH; r++) begin
                    e.row  = RAW'(r);
                    e.data = '0;
                    for (int c = 0; c < COLS; c++) e.data[c*ACC_BITS +: ACC_BITS] = mbuf[r][c];
                    expq.push_back(e);
                end
            end
        end
        tick(1'b1, f, l);
    endtask

    // val < 0 means random lane values; rows after row 0 carry random (ignored) flags.
    task automatic send_pass(input bit f, input bit l, input int val, input int gap_pct);
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < COLS; c++)
                vals[c] = (val < 0) ? lane_t'($urandom_range(0, (1 << INT_BITS) - 1)) : lane_t'(val);
            if (r == 0) send_row(f, l);
            else        send_row(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) < gap_pct) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        repeat (COLS + 1) tick(1'b0, 1'b0, 1'b0);
        while ((busy || expq.size() != 0) && n < 400) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("drain_in_budget", n < 400, 1);
    endtask

    task automatic wait_valid_row(input int row, output int n);
        n = 0;
        while (!(out_valid && out_row == RAW'(row)) && n < 100) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("valid_row_in_budget", n < 100, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int              n;
        logic [63:0]     d0;
        logic [RAW-1:0]  r0;

        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_psum = '0; out_ready = 1'b0;
        for (int a = 0; a < COLS; a++) for (int b = 0; b < COLS; b++) hist[a][b] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Deskew: lanes 1..3 follow column 0 by 1..3 cycles.
        rdy_mode = 1;
        vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
        send_row(1'b1, 1'b1);
        for (int c = 0; c < COLS; c++) vals[c] = '0;
        repeat (DEPTH - 1) send_row(1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("deskew_latency", n, 3);
        check("deskew_row", out_row, 0);
        check("deskew_data", out_data, 64'h0004_0003_0002_0001);
        rdy_mode = 0;
        wait_drain();

        // Three passes of 100 per lane.
        send_pass(1'b1, 1'b0, 100, 25);
        send_pass(1'b0, 1'b0, 100, 25);
        send_pass(1'b0, 1'b1, 100, 25);
        check("model_300", mbuf[3][2], 300);
        wait_valid_row(0, n);
        check("accum_data", out_data, {4{16'd300}});
        wait_drain();

        // Nine passes of 0x1FFF wrap modulo 2^16.
        for (int p = 0; p < 9; p++) send_pass(p == 0, p == 8, 'h1FFF, 0);
        check("model_wrap", mbuf[7][1], 16'h1FF7);
        wait_valid_row(0, n);
        check("wrap_data", out_data, 64'h1FF7_1FF7_1FF7_1FF7);
        wait_drain();

        // Backpressure mid-drain.
        rdy_mode = 1;
        send_pass(1'b1, 1'b1, -1, 0);
        wait_valid_row(3, n);
        rdy_mode = 2;
        r0 = out_row;
        d0 = out_data;
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        check("bp_valid_hold", out_valid, 1);
        check("bp_row_hold", out_row, r0);
        check("bp_data_hold", out_data, d0);
        rdy_mode = 0;
        wait_drain();

        // Back-to-back: next tile's row 0 aligns the cycle after the final drain handshake.
        rdy_mode = 1;
        send_pass(1'b1, 1'b1, -1, 0);
        wait_valid_row(DEPTH - COLS + 1, n);
        send_pass(1'b1, 1'b1, -1, 0);
        rdy_mode = 0;
        wait_drain();
        check("b2b_no_err", err, 0);

        // Upstream violation while draining.
        send_pass(1'b1, 1'b1, -1, 0);
        n = 0;
        while (!busy && n < 50) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("busy_in_budget", n < 50, 1);
        rdy_mode = 2;
        for (int c = 0; c < COLS; c++) vals[c] = lane_t'('h0AA);
        tick(1'b1, 1'b1, 1'b1);
        repeat (COLS + 1) tick(1'b0, 1'b0, 1'b0);
        check("err_set", err, 1);
        rdy_mode = 0;
        wait_drain();
        check("err_sticky", err, 1);

        // Reset mid-ACCUM after three rows.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < COLS; c++) vals[c] = lane_t'($urandom_range(1, 500));
            send_row(1'b1, 1'b1);
        end
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        check("midrst_out_row", out_row, 0);
        m_wr = 0;
        expq.delete();
        for (int a = 0; a < COLS; a++) for (int b = 0; b < COLS; b++) hist[a][b] = '0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_psum = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_pass(1'b1, 1'b0, -1, 20);
        send_pass(1'b0, 1'b1, -1, 20);
        wait_drain();

        // Random tiles with random pass counts, gaps and backpressure.
        for (int t = 0; t < 6; t++) begin
            int np;
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) send_pass(p == 0, p == np - 1, -1, 25);
            wait_drain();
        end

        check("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
